// File: rtl/sram_fifo_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two word FIFOs:
// TX (SPI->radio) in the lower half of the address space and RX (radio->SPI) in the upper half.
module sram_fifo_arbiter #(
    parameter int ADDR_W      = 11,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_wr,
    input  logic [15:0]       spi_wr_data,
    output logic              spi_wr_hint,
    input  logic              spi_rd,
    output logic [15:0]       spi_rd_data,
    output logic              spi_rd_hint,
    input  logic              radio_wr,
    input  logic [15:0]       radio_wr_data,
    output logic              radio_wr_hint,
    input  logic              radio_rd,
    output logic [15:0]       radio_rd_data,
    output logic              radio_rd_hint,
    output logic              tx_full,
    output logic              tx_empty,
    output logic              rx_full,
    output logic              rx_empty,
    output logic [ADDR_W-1:0] tx_count,
    output logic [ADDR_W-1:0] rx_count,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dout,
    input  logic [15:0]       sram_din,
    output logic              sram_ce,
    output logic              sram_we,
    output logic              sram_oe
);
    // state  | meaning
    // IDLE   | evaluate requests, latch grant/address/data
    // SETUP  | chip enable, address and write data on the bus
    // ACCESS | strobe held for WAIT_CYCLES, read data captured on the last cycle
    // DONE   | hint to the granted client, pointer/count update
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    localparam int PW = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] DEPTH = {1'b1, {PW{1'b0}}};

    state_t            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rr_q, rr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dout_q, dout_d;
    logic [3:0]        wait_q, wait_d;
    logic [PW-1:0]     tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [PW-1:0]     rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [ADDR_W-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic [15:0]       spi_rd_data_q, spi_rd_data_d, radio_rd_data_q, radio_rd_data_d;

    logic [3:0] elig;
    logic [1:0] pick, idx;
    logic       found;

    assign tx_full  = (tx_count_q == DEPTH);
    assign tx_empty = (tx_count_q == '0);
    assign rx_full  = (rx_count_q == DEPTH);
    assign rx_empty = (rx_count_q == '0);

    // Index order: 0=spi_wr, 1=radio_rd, 2=radio_wr, 3=spi_rd; even indices are writes.
    always_comb begin
        elig  = {spi_rd & ~rx_empty, radio_wr & ~rx_full, radio_rd & ~tx_empty, spi_wr & ~tx_full};
        found = 1'b0;
        pick  = rr_q;
        idx   = rr_q;
        for (int i = 0; i < 4; i++) begin
            idx = rr_q + 2'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        rr_d            = rr_q;
        addr_d          = addr_q;
        dout_d          = dout_q;
        wait_d          = wait_q;
        tx_wr_ptr_d     = tx_wr_ptr_q;
        tx_rd_ptr_d     = tx_rd_ptr_q;
        rx_wr_ptr_d     = rx_wr_ptr_q;
        rx_rd_ptr_d     = rx_rd_ptr_q;
        tx_count_d      = tx_count_q;
        rx_count_d      = rx_count_q;
        spi_rd_data_d   = spi_rd_data_q;
        radio_rd_data_d = radio_rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_SETUP;
                    gnt_d   = pick;
                    rr_d    = pick + 2'd1;
                    dout_d  = 16'h0000;
                    case (pick)
                        2'd0: begin
                            addr_d = {1'b0, tx_wr_ptr_q};
                            dout_d = spi_wr_data;
                        end
                        2'd1: addr_d = {1'b0, tx_rd_ptr_q};
                        2'd2: begin
                            addr_d = {1'b1, rx_wr_ptr_q};
                            dout_d = radio_wr_data;
                        end
                        default: addr_d = {1'b1, rx_rd_ptr_q};
                    endcase
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                wait_d  = 4'(WAIT_CYCLES - 1);
            end
            S_ACCESS: begin
                if (wait_q == 4'd0) begin
                    state_d = S_DONE;
                    // Loading here makes the new word visible together with the hint.
                    if (gnt_q == 2'd1) radio_rd_data_d = sram_din;
                    if (gnt_q == 2'd3) spi_rd_data_d   = sram_din;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                case (gnt_q)
                    2'd0: begin
                        tx_wr_ptr_d = tx_wr_ptr_q + PW'(1);
                        tx_count_d  = tx_count_q + ADDR_W'(1);
                    end
                    2'd1: begin
                        tx_rd_ptr_d = tx_rd_ptr_q + PW'(1);
                        tx_count_d  = tx_count_q - ADDR_W'(1);
                    end
                    2'd2: begin
                        rx_wr_ptr_d = rx_wr_ptr_q + PW'(1);
                        rx_count_d  = rx_count_q + ADDR_W'(1);
                    end
                    default: begin
                        rx_rd_ptr_d = rx_rd_ptr_q + PW'(1);
                        rx_count_d  = rx_count_q - ADDR_W'(1);
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            gnt_q           <= 2'd0;
            rr_q            <= 2'd0;
            addr_q          <= '0;
            dout_q          <= 16'h0000;
            wait_q          <= 4'd0;
            tx_wr_ptr_q     <= '0;
            tx_rd_ptr_q     <= '0;
            rx_wr_ptr_q     <= '0;
            rx_rd_ptr_q     <= '0;
            tx_count_q      <= '0;
            rx_count_q      <= '0;
            spi_rd_data_q   <= 16'h0000;
            radio_rd_data_q <= 16'h0000;
        end else begin
            state_q         <= state_d;
            gnt_q           <= gnt_d;
            rr_q            <= rr_d;
            addr_q          <= addr_d;
            dout_q          <= dout_d;
            wait_q          <= wait_d;
            tx_wr_ptr_q     <= tx_wr_ptr_d;
            tx_rd_ptr_q     <= tx_rd_ptr_d;
            rx_wr_ptr_q     <= rx_wr_ptr_d;
            rx_rd_ptr_q     <= rx_rd_ptr_d;
            tx_count_q      <= tx_count_d;
            rx_count_q      <= rx_count_d;
            spi_rd_data_q   <= spi_rd_data_d;
            radio_rd_data_q <= radio_rd_data_d;
        end
    end

    // Strobes decode straight from the state flop so an async reset drops them at once.
    assign sram_ce       = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign sram_we       = (state_q == S_ACCESS) && !gnt_q[0];
    assign sram_oe       = (state_q == S_ACCESS) && gnt_q[0];
    assign sram_addr     = addr_q;
    assign sram_dout     = dout_q;
    assign spi_wr_hint   = (state_q == S_DONE) && (gnt_q == 2'd0);
    assign radio_rd_hint = (state_q == S_DONE) && (gnt_q == 2'd1);
    assign radio_wr_hint = (state_q == S_DONE) && (gnt_q == 2'd2);
    assign spi_rd_hint   = (state_q == S_DONE) && (gnt_q == 2'd3);
    assign tx_count      = tx_count_q;
    assign rx_count      = rx_count_q;
    assign spi_rd_data   = spi_rd_data_q;
    assign radio_rd_data = radio_rd_data_q;
endmodule
